// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - stream output bundle for fifo_rd_stream
interface fifo_rd_stream_if #(
    parameter int B = 8
);
    logic [B-1:0] m_data;
    logic         m_valid;
    logic         m_last;
    logic         m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - pops a cfg_len-word frame from a FWFT FIFO onto a stream
module fifo_rd_stream #(
    parameter int B = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [B-1:0]      fifo_r_data,
    input  logic              fifo_valid,
    output logic              fifo_rd,
    input  logic              start,
    input  logic [7:0]        cfg_len,
    fifo_rd_stream_if.master  m,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t       state, state_n;
    logic [7:0]   remaining;
    logic [1:0]   buf_count, count_n;
    logic [B-1:0] d0, d1;
    logic         l0, l1;
    logic         valid_q;
    logic         push, pop, push_last;

    // Read decision uses only registered state and the FIFO flag, never m_ready.
    assign fifo_rd   = (state == RUN) && (remaining != 8'd0) && !fifo_empty && (buf_count < 2'd2);
    assign push      = fifo_rd;
    assign push_last = (remaining == 8'd1);
    assign pop       = valid_q && m.m_ready;

    assign m.m_valid = valid_q;
    assign m.m_data  = d0;
    assign m.m_last  = l0;

    always_comb begin
        state_n = state;
        count_n = buf_count + {1'b0, push} - {1'b0, pop};
        case (state)
            IDLE:    if (start && cfg_len != 8'd0) state_n = RUN;
            RUN:     if (push && push_last)        state_n = DRAIN;
            DRAIN:   if (pop && l0)                state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= 8'd0;
            buf_count <= 2'd0;
            valid_q   <= 1'b0;
            d0        <= '0;
            d1        <= '0;
            l0        <= 1'b0;
            l1        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            buf_count <= count_n;
            valid_q   <= (count_n != 2'd0);
            busy      <= (state_n != IDLE);
            done      <= ((state == IDLE) && start && (cfg_len == 8'd0)) ||
                         ((state == DRAIN) && pop && l0);
            if (fifo_rd && !fifo_valid)
                err <= 1'b1;

            if (state == IDLE && start)
                remaining <= cfg_len;
            else if (push)
                remaining <= remaining - 8'd1;

            // Head takes the new word when the buffer is empty or is emptying this cycle.
            if (push && (buf_count == 2'd0 || (buf_count == 2'd1 && pop))) begin
                d0 <= fifo_r_data;
                l0 <= push_last;
            end else if (pop) begin
                d0 <= d1;
                l0 <= l1;
            end
            if (push && buf_count == 2'd1 && !pop) begin
                d1 <= fifo_r_data;
                l1 <= push_last;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream
module tb_fifo_rd_stream;
    localparam int B = 8;

    typedef struct {
        logic [B-1:0] d;
        bit           last;
    } item_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         fifo_empty = 1'b1;
    logic [B-1:0] fifo_r_data = '0;
    logic         fifo_valid;
    logic         fifo_rd;
    logic         start = 1'b0;
    logic [7:0]   cfg_len = 8'd0;
    logic         busy, done, err;
    logic         kill_valid = 1'b0;

    fifo_rd_stream_if #(.B(B)) sif ();

    fifo_rd_stream #(.B(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_r_data(fifo_r_data),
        .fifo_valid (fifo_valid),
        .fifo_rd    (fifo_rd),
        .start      (start),
        .cfg_len    (cfg_len),
        .m          (sif.master),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    assign fifo_valid = fifo_rd & ~kill_valid;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [B-1:0] fq[$];
    logic [B-1:0] pend[$];
    item_t        exp_q[$];

    bit exp_acc = 0, exp_zl = 0, feed = 0, rand_ready = 0;
    bit exp_busy = 0, exp_done = 0, exp_err = 0;
    bit rd_s, mv_s, dn_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty  = (fq.size() == 0);
        fifo_r_data = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // One clock: sample at the falling edge, then act just after the rising edge.
    task automatic step();
        @(negedge clk);
        rd_s = fifo_rd;
        mv_s = sif.m_valid;
        dn_s = done;
        @(posedge clk);
        #1;
        if (rd_s && fq.size() != 0) void'(fq.pop_front());
        start      = 1'b0;
        exp_acc    = 0;
        exp_zl     = 0;
        kill_valid = 1'b0;
        if (feed && pend.size() != 0 && $urandom_range(0, 2) != 0)
            fq.push_back(pend.pop_front());
        if (rand_ready) sif.m_ready = ($urandom_range(0, 3) != 0);
        refresh();
    endtask

    task automatic frame(input int len, input bit direct, input bit pat);
        item_t it;
        for (int i = 0; i < len; i++) begin
            it.d    = pat ? B'(8'h11 * (i + 1)) : B'($urandom);
            it.last = (i == len - 1);
            exp_q.push_back(it);
            if (direct) fq.push_back(it.d);
            else        pend.push_back(it.d);
        end
        start   = 1'b1;
        cfg_len = 8'(len);
        exp_acc = (len != 0);
        exp_zl  = (len == 0);
        refresh();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp_busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d words left expected 0", exp_q.size());
        end
        step();
    endtask

    // Monitor: occupancy is counted from reads and handshakes, independent of buffer layout.
    int           occ = 0;
    bit           prev_stall = 0;
    logic [B-1:0] prev_data;
    logic         prev_last;
    item_t        got;
    bit           hs, last_hs;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_m_valid", sif.m_valid, 0);
            chk("rst_m_last", sif.m_last, 0);
            chk("rst_m_data", sif.m_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_fifo_rd", fifo_rd, 0);
            occ = 0; prev_stall = 0;
            exp_busy = 0; exp_done = 0; exp_err = 0;
        end else begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("err", err, exp_err);
            chk("m_valid", sif.m_valid, occ != 0);
            if (fifo_empty) chk("rd_while_empty", fifo_rd, 0);
            if (!exp_busy)  chk("rd_while_idle", fifo_rd, 0);
            if (prev_stall) begin
                chk("hold_data", sif.m_data, prev_data);
                chk("hold_last", sif.m_last, prev_last);
            end
            hs      = sif.m_valid && sif.m_ready;
            last_hs = 0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %0h expected none", sif.m_data);
                end else begin
                    got = exp_q.pop_front();
                    chk("m_data", sif.m_data, got.d);
                    chk("m_last", sif.m_last, got.last);
                    last_hs = got.last;
                end
            end
            occ = occ + int'(fifo_rd) - int'(hs);
            chk("buffer_bound", occ <= 2, 1);
            if (fifo_rd && !fifo_valid) exp_err = 1;
            exp_done = exp_zl || last_hs;
            if (exp_acc)      exp_busy = 1;
            else if (last_hs) exp_busy = 0;
            prev_stall = sif.m_valid && !sif.m_ready;
            prev_data  = sif.m_data;
            prev_last  = sif.m_last;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    int exp_rd[7] = '{0, 1, 1, 1, 1, 0, 0};
    int exp_mv[7] = '{0, 0, 1, 1, 1, 1, 0};
    int exp_dn[7] = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        sif.m_ready = 1'b1;
        fq.push_back(8'hA5);
        refresh();
        step();
        step();
        reset = 1'b0;
        fq.delete();
        refresh();
        step();

        // Back-to-back frame with cycle-exact latency
        frame(4, 1, 1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("lat_rd%0d", i), rd_s, exp_rd[i]);
            chk($sformatf("lat_mv%0d", i), mv_s, exp_mv[i]);
            chk($sformatf("lat_done%0d", i), dn_s, exp_dn[i]);
        end

        // Backpressure in cycles 3..6 of the frame
        frame(6, 1, 0);
        for (int i = 0; i < 12; i++) begin
            step();
            sif.m_ready = !((i + 1) >= 3 && (i + 1) <= 6);
        end
        sif.m_ready = 1'b1;
        wait_done(100);

        // Underflow stall: one word now, two more five cycles later
        frame(3, 0, 0);
        fq.push_back(pend.pop_front());
        refresh();
        for (int i = 0; i < 5; i++) step();
        while (pend.size() != 0) fq.push_back(pend.pop_front());
        refresh();
        wait_done(100);

        // Zero-length frame with words waiting in the FIFO
        fq.push_back(8'h5A);
        frame(0, 1, 0);
        step();
        step();
        step();
        fq.delete();
        refresh();

        // Start during RUN is ignored
        frame(5, 1, 0);
        step();
        step();
        start   = 1'b1;
        cfg_len = 8'd9;
        for (int i = 0; i < 4; i++) fq.push_back(8'hEE);
        refresh();
        wait_done(100);
        fq.delete();
        refresh();

        // Read with fifo_valid low sets sticky err, then reset mid-frame
        frame(8, 1, 0);
        step();
        kill_valid = 1'b1;
        step();
        step();
        step();
        reset = 1'b1;
        exp_q.delete();
        pend.delete();
        fq.delete();
        refresh();
        step();
        step();
        reset = 1'b0;
        step();
        frame(5, 1, 0);
        wait_done(100);

        // Randomized frames, random supply and random backpressure
        feed       = 1;
        rand_ready = 1;
        for (int f = 0; f < 30; f++) begin
            frame((f % 7 == 6) ? 0 : $urandom_range(1, 12), 0, 0);
            wait_done(400);
        end
        frame(255, 0, 0);
        wait_done(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
